// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the receive and transmit units
//
// Purpose : FSM state encoding, data width and default baud divisor used by
//           the UART RX/TX blocks.
// Ports   : none (package)
// Macros  : none

package uart_pkg;

  // Character width (8N1 framing)
  localparam int UART_DATA_W = 8;

  // 50 MHz system clock / 115200 baud
  localparam int UART_CLKS_PER_BIT_DEF = 434;

  // Receive/transmit FSM encoding. PARITY is only reachable when the
  // parity option is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } uart_state_e;

  // Even parity: the parity bit makes the total number of ones even
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word fall-through byte FIFO with overrun pulse
//
// Purpose : Small synchronous FIFO. The head entry is always presented on
//           data while empty is low; a pop advances to the next entry.
// Ports   : clk, rst       - clock, synchronous active-low reset
//           push, push_data - write request and byte
//           pop            - remove head entry (ignored when empty)
//           data           - head entry (8'h00 when empty)
//           empty, full    - registered occupancy flags
//           overrun        - one-cycle pulse: push refused because full
// Macros  : none

module uart_rx_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             empty,
  output logic             full,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    count;
  logic [PW-1:0]    count_next;
  logic             empty_q;
  logic             full_q;
  logic             do_push;
  logic             do_pop;

  // A pop is only honoured when something is held. A push into a full FIFO
  // is allowed only when the same-cycle pop frees the slot.
  assign do_pop  = pop && !empty_q;
  assign do_push = push && (!full_q || do_pop);
  assign overrun = push && full_q && !do_pop;

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + PW'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count   <= count_next;
      empty_q <= (count_next == '0);
      full_q  <= (count_next == PW'(DEPTH));
    end
  end

  // Storage needs no reset: the output is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  assign data  = empty_q ? '0 : mem[rd_ptr[AW-1:0]];
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/uart_rx_unit.sv
// rtl/uart_rx_unit.sv - UART serial receiver with receive FIFO
//
// Purpose : Synchronises the serial line, frames 8N1 characters (LSB first,
//           idle high), samples each bit at mid-bit and pushes good bytes
//           into a FWFT FIFO read by the MMIO load path.
// Ports   : clk, rst           - clock, synchronous active-low reset
//           uart_input_line    - asynchronous serial input
//           uart_fifo_read_en  - pop head byte
//           uart_fifo_data     - head byte (valid when fifo_empty=0)
//           fifo_empty, fifo_full - FIFO occupancy
//           frame_error        - pulse: stop bit sampled low
//           overrun            - pulse: byte dropped, FIFO full
//           parity_error       - pulse: even-parity mismatch
// Macros  : UART_RX_PARITY_EN - adds an even-parity bit between data and stop

module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int DEPTH        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_input_line,
  input  logic                   uart_fifo_read_en,
  output logic [UART_DATA_W-1:0] uart_fifo_data,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic                   frame_error,
  output logic                   overrun,
  output logic                   parity_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  localparam uart_state_e AFTER_DATA = ST_PARITY;
`else
  localparam uart_state_e AFTER_DATA = ST_STOP;
`endif

  logic                   sync1;
  logic                   rx_s;
  uart_state_e            state;
  uart_state_e            state_next;
  logic [CNT_W-1:0]       baud_cnt;
  logic [CNT_W-1:0]       baud_next;
  logic [2:0]             bit_cnt;
  logic [2:0]             bit_next;
  logic [UART_DATA_W-1:0] shift_q;
  logic [UART_DATA_W-1:0] shift_next;
  logic                   push;
  logic                   frame_err_c;
  logic                   parity_err_c;
`ifdef UART_RX_PARITY_EN
  logic                   par_q;
  logic                   par_next;
`endif

  // Two-flop synchroniser, preset to the idle level so reset never looks
  // like a start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= uart_input_line;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
`ifdef UART_RX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      shift_q  <= shift_next;
`ifdef UART_RX_PARITY_EN
      par_q    <= par_next;
`endif
    end
  end

  always_comb begin
    state_next   = state;
    baud_next    = baud_cnt + CNT_W'(1);
    bit_next     = bit_cnt;
    shift_next   = shift_q;
    push         = 1'b0;
    frame_err_c  = 1'b0;
    parity_err_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_next     = par_q;
`endif
    case (state)
      ST_IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (!rx_s) state_next = ST_START;
      end
      // Re-check the line at the middle of the start bit; a high level here
      // was a glitch and is dropped silently.
      ST_START: begin
        if (baud_cnt == HALF_END) begin
          baud_next  = '0;
          state_next = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      // Counting a full bit from the start-bit centre lands on each data
      // bit centre. Bits arrive LSB first, so shift in from the top.
      ST_DATA: begin
        if (baud_cnt == BIT_END) begin
          baud_next  = '0;
          shift_next = {rx_s, shift_q[UART_DATA_W-1:1]};
          bit_next   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = AFTER_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (baud_cnt == BIT_END) begin
          baud_next  = '0;
          par_next   = rx_s;
          state_next = ST_STOP;
        end
      end
`endif
      // Leaving at the stop-bit centre gives half a bit of slack to catch
      // the next start edge of a back-to-back frame.
      ST_STOP: begin
        if (baud_cnt == BIT_END) begin
          baud_next   = '0;
          state_next  = ST_IDLE;
          frame_err_c = !rx_s;
`ifdef UART_RX_PARITY_EN
          parity_err_c = (even_parity(shift_q) != par_q);
          push         = rx_s && !parity_err_c;
`else
          push         = rx_s;
`endif
        end
      end
      default: begin
        baud_next  = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift_q),
    .pop       (uart_fifo_read_en),
    .data      (uart_fifo_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .overrun   (overrun)
  );

  assign frame_error  = frame_err_c;
  assign parity_error = parity_err_c;

endmodule

// File: tb/tb_uart_rx_unit.sv
// tb/tb_uart_rx_unit.sv - scoreboard testbench for uart_rx_unit

module tb_uart_rx_unit;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       line = 1'b0;
  logic       read_en = 1'b0;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_full;
  logic       frame_error;
  logic       overrun;
  logic       parity_error;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  logic [7:0] exp_q[$];
  int exp_ov = 0;
  int exp_fe = 0;
  int exp_pe = 0;

  uart_rx_unit #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .uart_input_line   (line),
    .uart_fifo_read_en (read_en),
    .uart_fifo_data    (fifo_data),
    .fifo_empty        (fifo_empty),
    .fifo_full         (fifo_full),
    .frame_error       (frame_error),
    .overrun           (overrun),
    .parity_error      (parity_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (frame_error)  fe_cnt++;
      if (overrun)      ov_cnt++;
      if (parity_error) pe_cnt++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    line = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // stop_low_cycles > 0 holds the stop bit low for that many cycles, long
  // enough to cover the stop sample but short enough that the receiver's
  // re-armed start check sees the line high again.
  task automatic send_frame(input logic [7:0] d, input logic par,
                            input int stop_low_cycles);
    logic good;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive_bit(par, CPB);
    good = (par == ^d);
    if (!good) exp_pe++;
`else
    good = 1'b1;
    if (par) good = 1'b1;
`endif
    if (stop_low_cycles > 0) begin
      drive_bit(1'b0, stop_low_cycles);
      line = 1'b1;
      exp_fe++;
      good = 1'b0;
    end else begin
      drive_bit(1'b1, CPB);
    end
    if (good) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else exp_ov++;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_underflow"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_empty"}, int'(fifo_empty), 0);
    check({tag, "_data"}, int'(fifo_data), int'(e));
    read_en = 1'b1;
    @(posedge clk);
    #1;
    read_en = 1'b0;
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with the line held low
    rst  = 1'b0;
    line = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    line = 1'b1;
    rst  = 1'b1;
    idle(40);
    check("rst_empty", int'(fifo_empty), 1);
    check("rst_full", int'(fifo_full), 0);
    check("rst_data", int'(fifo_data), 0);
    check("rst_pulses", fe_cnt + ov_cnt + pe_cnt, 0);

    // Single frame
    send_frame(8'hA5, ^8'hA5, 0);
    idle(4);
    pop_check("a5");
    check("a5_empty_after_pop", int'(fifo_empty), 1);

    // Back-to-back frames fill the FIFO, fifth overruns
    send_frame(8'hFF, ^8'hFF, 0);
    send_frame(8'h00, ^8'h00, 0);
    send_frame(8'hFF, ^8'hFF, 0);
    send_frame(8'h00, ^8'h00, 0);
    idle(4);
    check("b2b_full", int'(fifo_full), 1);
    send_frame(8'h3C, ^8'h3C, 0);
    idle(4);
    check("overrun_count", ov_cnt, exp_ov);
    check("overrun_once", ov_cnt, 1);
    for (int i = 0; i < DEPTH; i++) pop_check("b2b_pop");
    check("b2b_empty", int'(fifo_empty), 1);

    // Start-bit glitch
    drive_bit(1'b0, 4);
    idle(5 * CPB);
    check("glitch_empty", int'(fifo_empty), 1);
    check("glitch_fe", fe_cnt, 0);

    // Bad stop bit
    send_frame(8'h55, ^8'h55, CPB / 2 + 4);
    idle(3 * CPB);
    check("fe_count", fe_cnt, exp_fe);
    check("fe_once", fe_cnt, 1);
    check("fe_empty", int'(fifo_empty), 1);

    // Reset mid-frame abandons the partial byte
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, 3 * CPB);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(12 * CPB);
    check("midrst_empty", int'(fifo_empty), 1);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 0);
    idle(4);
    pop_check("par_good");
    send_frame(8'h07, 1'b0, 0);
    idle(4);
    check("par_err_count", pe_cnt, exp_pe);
    check("par_err_once", pe_cnt, 1);
    check("par_bad_empty", int'(fifo_empty), 1);
`else
    check("no_parity_pulse", pe_cnt, 0);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    check("final_overrun", ov_cnt, exp_ov);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
